// File: rtl/fp_div_issue_if.sv
// Request, divider and result signal bundle for the FP32 divider issue stage.
// Handshake: a transfer happens on a rising edge with valid && ready high; out_* hold while out_valid && !out_ready.
interface fp_div_issue_if #(
   parameter int TAG_W = 4
);
   logic             in_valid;
   logic             in_ready;
   logic [31:0]      in_a;
   logic [31:0]      in_b;
   logic [TAG_W-1:0] in_tag;

   logic [31:0]      div_a;
   logic [31:0]      div_b;
   logic             div_en;
   logic [31:0]      div_result;
   logic             div_ready;
   logic             div_nan;

   logic             out_valid;
   logic             out_ready;
   logic [31:0]      out_result;
   logic             out_nan;
   logic             out_timeout;
   logic [TAG_W-1:0] out_tag;

   modport slave (
      input  in_valid, in_a, in_b, in_tag, div_result, div_ready, div_nan, out_ready,
      output in_ready, div_a, div_b, div_en, out_valid, out_result, out_nan, out_timeout, out_tag
   );

   modport master (
      output in_valid, in_a, in_b, in_tag, div_result, div_ready, div_nan, out_ready,
      input  in_ready, div_a, div_b, div_en, out_valid, out_result, out_nan, out_timeout, out_tag
   );
endinterface

// File: rtl/fp_div_issue.sv
// Operand FIFO and one-at-a-time sequencer in front of the FP32 divider, with a
// tagged result register and a watchdog that aborts a hung divide.
module fp_div_issue #(
   parameter int DEPTH   = 4,
   parameter int TAG_W   = 4,
   parameter int TIMEOUT = 64
) (
   input  logic                   clk,
   input  logic                   reset_n,
   fp_div_issue_if.slave          bus,
   output logic                   busy,
   output logic [$clog2(DEPTH):0] fifo_count,
   output logic                   err_sticky,
   output logic [1:0]             state_dbg
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int WD_W  = $clog2(TIMEOUT);
   localparam logic [31:0] QNAN = 32'h7FC0_0000;

   typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2, DONE = 2'd3} state_t;
   state_t state, state_next;

   logic [31:0]      mem_a   [DEPTH];
   logic [31:0]      mem_b   [DEPTH];
   logic [TAG_W-1:0] mem_tag [DEPTH];
   logic [PTR_W-1:0] wr_ptr, rd_ptr;
   logic [CNT_W-1:0] count;
   logic             full, empty, push, pop;

   logic [31:0]      a_q, b_q;
   logic [TAG_W-1:0] tag_q;
   logic [WD_W-1:0]  wd;
   logic             out_valid_q, out_nan_q, out_timeout_q;
   logic [31:0]      out_result_q;
   logic [TAG_W-1:0] out_tag_q;
   logic             done_pulse, capture, expire;

   assign full       = (count == CNT_W'(DEPTH));
   assign empty      = (count == '0);
   assign push       = bus.in_valid && !full;
   assign done_pulse = bus.div_ready || bus.div_nan;
   assign capture    = (state == WAIT) && done_pulse;
   assign expire     = (state == WAIT) && !done_pulse && (wd == WD_W'(TIMEOUT - 1));

   // Issue only when the output slot is free, so a completion never meets back-pressure.
   always_comb begin
      state_next = state;
      pop        = 1'b0;
      case (state)
         IDLE: begin
            if (!empty && (!out_valid_q || bus.out_ready)) begin
               pop        = 1'b1;
               state_next = ISSUE;
            end
         end
         ISSUE:   state_next = WAIT;
         WAIT:    if (capture || expire) state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_next;
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem_a[wr_ptr]   <= bus.in_a;
         mem_b[wr_ptr]   <= bus.in_b;
         mem_tag[wr_ptr] <= bus.in_tag;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         a_q           <= '0;
         b_q           <= '0;
         tag_q         <= '0;
         wd            <= '0;
         out_valid_q   <= 1'b0;
         out_result_q  <= '0;
         out_nan_q     <= 1'b0;
         out_timeout_q <= 1'b0;
         out_tag_q     <= '0;
         err_sticky    <= 1'b0;
      end else begin
         if (pop) begin
            a_q   <= mem_a[rd_ptr];
            b_q   <= mem_b[rd_ptr];
            tag_q <= mem_tag[rd_ptr];
         end
         if (state == ISSUE)     wd <= '0;
         else if (state == WAIT) wd <= wd + 1'b1;
         // NaN takes precedence when both completion pulses arrive together.
         if (capture) begin
            out_valid_q   <= 1'b1;
            out_result_q  <= bus.div_nan ? QNAN : bus.div_result;
            out_nan_q     <= bus.div_nan;
            out_timeout_q <= 1'b0;
            out_tag_q     <= tag_q;
         end else if (expire) begin
            out_valid_q   <= 1'b1;
            out_result_q  <= QNAN;
            out_nan_q     <= 1'b1;
            out_timeout_q <= 1'b1;
            out_tag_q     <= tag_q;
            err_sticky    <= 1'b1;
         end else if (out_valid_q && bus.out_ready) begin
            out_valid_q <= 1'b0;
         end
      end
   end

   assign bus.in_ready    = !full;
   assign bus.div_a       = a_q;
   assign bus.div_b       = b_q;
   assign bus.div_en      = (state == ISSUE);
   assign bus.out_valid   = out_valid_q;
   assign bus.out_result  = out_result_q;
   assign bus.out_nan     = out_nan_q;
   assign bus.out_timeout = out_timeout_q;
   assign bus.out_tag     = out_tag_q;
   assign busy            = (state != IDLE) || !empty;
   assign fifo_count      = count;
   assign state_dbg       = state;
endmodule

// File: tb/tb_fp_div_issue.sv
// Bench for fp_div_issue: behavioural divider model, scoreboard of expected
// results, and a directed sequence covering issue, NaN, back-pressure, watchdog and reset.
module tb_fp_div_issue;
   localparam int TAG_W   = 4;
   localparam int DEPTH   = 4;
   localparam int TIMEOUT = 64;
   localparam int LAT     = 5;
   localparam int W       = 32 + 2 + TAG_W;
   localparam logic [31:0] QNAN = 32'h7FC0_0000;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       busy, err_sticky;
   logic [2:0] fifo_count;
   logic [1:0] state_dbg;

   always #5 clk = ~clk;

   fp_div_issue_if #(.TAG_W(TAG_W)) bus ();

   fp_div_issue #(.DEPTH(DEPTH), .TAG_W(TAG_W), .TIMEOUT(TIMEOUT)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .bus        (bus),
      .busy       (busy),
      .fifo_count (fifo_count),
      .err_sticky (err_sticky),
      .state_dbg  (state_dbg)
   );

   int n_vec  = 0;
   int n_miss = 0;
   logic [W-1:0] exp_q [$];

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      assert (got === exp) else begin
         n_miss++;
         $error("FAIL %s observed=%h expected=%h", tag, got, exp);
      end
   endtask

   // Divider model: the quotient table stands in for the real FP32 divider.
   function automatic logic [32:0] model_div(input logic [31:0] a, input logic [31:0] b);
      if (a == 32'h40C0_0000 && b == 32'h4000_0000) return {1'b0, 32'h4040_0000};
      if (a == 32'h3F80_0000 && b == 32'h4080_0000) return {1'b0, 32'h3E80_0000};
      if (a == 32'h4120_0000 && b == 32'h40A0_0000) return {1'b0, 32'h4000_0000};
      if (a == 32'h3F80_0000 && b == 32'h4000_0000) return {1'b0, 32'h3F00_0000};
      if (a == 32'h4110_0000 && b == 32'h4040_0000) return {1'b0, 32'h4040_0000};
      if (a == 32'h4100_0000 && b == 32'h4080_0000) return {1'b0, 32'h4000_0000};
      if (a == 32'hC0C0_0000 && b == 32'h4000_0000) return {1'b0, 32'hC040_0000};
      if (a == 32'h0 && b == 32'h0)                 return {1'b1, QNAN};
      return {1'b0, 32'hBAD0_BAD0};
   endfunction

   logic        hang = 1'b0;
   logic        both = 1'b0;
   int          late_req = 0;
   int          late_seen = 0;
   int          ctr = 0;
   int          en_count = 0;
   logic        prev_en = 1'b0;
   logic [31:0] ma, mb;
   logic [32:0] mres;

   always @(negedge clk) begin
      bus.div_ready = 1'b0;
      bus.div_nan   = 1'b0;
      if (!reset_n) begin
         ctr     = 0;
         prev_en = 1'b0;
      end else begin
         if (bus.div_en) begin
            en_count++;
            check("en_one_cycle", 64'(prev_en), 64'd0);
            ctr = LAT;
            ma  = bus.div_a;
            mb  = bus.div_b;
         end else if (ctr > 0) begin
            ctr--;
            if (ctr == 0 && !hang) begin
               check("div_ab_hold", {bus.div_a, bus.div_b}, {ma, mb});
               mres = model_div(ma, mb);
               if (both) begin
                  bus.div_ready  = 1'b1;
                  bus.div_nan    = 1'b1;
                  bus.div_result = 32'h4040_0000;
               end else if (mres[32]) begin
                  bus.div_nan    = 1'b1;
                  bus.div_result = mres[31:0];
               end else begin
                  bus.div_ready  = 1'b1;
                  bus.div_result = mres[31:0];
               end
            end
         end
         if (late_req != late_seen) begin
            late_seen      = late_req;
            bus.div_ready  = 1'b1;
            bus.div_result = 32'h3F80_0000;
         end
         prev_en = bus.div_en;
      end
   end

   always @(negedge clk) begin
      if (reset_n && bus.out_valid && bus.out_ready) begin
         check("sb_nonempty", 64'(exp_q.size() != 0), 64'd1);
         if (exp_q.size() != 0)
            check("sb_result", {bus.out_result, bus.out_nan, bus.out_timeout, bus.out_tag}, exp_q.pop_front());
      end
   end

   task automatic tick(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic push_req(input logic [31:0] a, input logic [31:0] b, input logic [TAG_W-1:0] tag,
                           input logic [31:0] er, input logic en, input logic et);
      int guard = 0;
      while (!bus.in_ready && guard < 500) begin
         tick();
         guard++;
      end
      check("push_ready", 64'(bus.in_ready), 64'd1);
      bus.in_valid = 1'b1;
      bus.in_a     = a;
      bus.in_b     = b;
      bus.in_tag   = tag;
      exp_q.push_back({er, en, et, tag});
      tick();
      bus.in_valid = 1'b0;
   endtask

   task automatic drain(input string tag);
      int k = 0;
      while ((exp_q.size() != 0 || busy) && k < 500) begin
         tick();
         k++;
      end
      check(tag, 64'(exp_q.size() == 0 && !busy), 64'd1);
   endtask

   task automatic wait_out(input string tag, input int max);
      int k = 0;
      while (!bus.out_valid && k < max) begin
         tick();
         k++;
      end
      check(tag, 64'(bus.out_valid), 64'd1);
   endtask

   logic [31:0] tab_a [7] = '{32'h40C0_0000, 32'h3F80_0000, 32'h4120_0000, 32'h3F80_0000,
                              32'h4110_0000, 32'h4100_0000, 32'hC0C0_0000};
   logic [31:0] tab_b [7] = '{32'h4000_0000, 32'h4080_0000, 32'h40A0_0000, 32'h4000_0000,
                              32'h4040_0000, 32'h4080_0000, 32'h4000_0000};
   logic [31:0] tab_q [7] = '{32'h4040_0000, 32'h3E80_0000, 32'h4000_0000, 32'h3F00_0000,
                              32'h4040_0000, 32'h4000_0000, 32'hC040_0000};

   initial begin
      #1000000;
      $display("FAIL global_timeout observed=stalled expected=finished");
      $fatal(1, "bench stalled");
   end

   initial begin
      int e0;
      int k;
      int idx;
      bus.in_valid  = 1'b0;
      bus.in_a      = '0;
      bus.in_b      = '0;
      bus.in_tag    = '0;
      bus.out_ready = 1'b1;
      tick(3);
      check("rst_in_ready", 64'(bus.in_ready), 64'd1);
      check("rst_outs", {bus.out_valid, bus.out_nan, bus.out_timeout, bus.out_tag, bus.div_en, busy, err_sticky},
            64'd0);
      check("rst_count", 64'(fifo_count), 64'd0);
      check("rst_data", {bus.out_result, bus.div_a}, 64'd0);
      check("rst_state", 64'(state_dbg), 64'd0);
      reset_n = 1'b1;
      tick(2);

      // 6.0 / 2.0 with issue timing
      e0 = en_count;
      push_req(32'h40C0_0000, 32'h4000_0000, 4'd3, 32'h4040_0000, 1'b0, 1'b0);
      check("lat_count_after_push", 64'(fifo_count), 64'd1);
      check("lat_en_low", 64'(bus.div_en), 64'd0);
      tick();
      check("lat_en_high", 64'(bus.div_en), 64'd1);
      check("lat_popped", 64'(fifo_count), 64'd0);
      tick();
      check("lat_en_drop", 64'(bus.div_en), 64'd0);
      drain("drain_6div2");
      check("en_6div2", 64'(en_count - e0), 64'd1);

      push_req(32'h0, 32'h0, 4'd6, QNAN, 1'b1, 1'b0);
      drain("drain_0div0");

      both = 1'b1;
      push_req(32'h3F80_0000, 32'h4000_0000, 4'd7, QNAN, 1'b1, 1'b0);
      drain("drain_both");
      both = 1'b0;

      // Fill with the consumer stalled
      bus.out_ready = 1'b0;
      e0 = en_count;
      push_req(tab_a[2], tab_b[2], 4'd1, tab_q[2], 1'b0, 1'b0);
      push_req(tab_a[3], tab_b[3], 4'd2, tab_q[3], 1'b0, 1'b0);
      push_req(tab_a[4], tab_b[4], 4'd3, tab_q[4], 1'b0, 1'b0);
      push_req(tab_a[5], tab_b[5], 4'd4, tab_q[5], 1'b0, 1'b0);
      push_req(tab_a[6], tab_b[6], 4'd5, tab_q[6], 1'b0, 1'b0);
      check("full_count", 64'(fifo_count), 64'd4);
      check("full_in_ready", 64'(bus.in_ready), 64'd0);
      wait_out("fill_first_valid", 50);
      bus.in_valid = 1'b1;
      bus.in_a     = 32'hDEAD_0000;
      bus.in_b     = 32'hDEAD_0001;
      bus.in_tag   = 4'hF;
      for (int i = 0; i < 20; i++) begin
         tick();
         check("bp_hold", {bus.out_valid, bus.out_result, bus.out_nan, bus.out_timeout, bus.out_tag},
               {1'b1, 32'h4000_0000, 1'b0, 1'b0, 4'd1});
         check("bp_count", 64'(fifo_count), 64'd4);
      end
      check("bp_no_issue", 64'(en_count - e0), 64'd1);
      bus.out_ready = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      check("full_pop_no_push", 64'(fifo_count), 64'd3);
      drain("drain_fill");
      check("en_fill", 64'(en_count - e0), 64'd5);

      // Hung divider and watchdog
      hang = 1'b1;
      push_req(32'h3F80_0000, 32'h4080_0000, 4'd9, QNAN, 1'b1, 1'b1);
      k = 0;
      while (!bus.div_en && k < 20) begin
         tick();
         k++;
      end
      check("wd_en_seen", 64'(bus.div_en), 64'd1);
      k = 0;
      while (!bus.out_valid && k < 200) begin
         tick();
         k++;
      end
      check("wd_latency", 64'(k), 64'(TIMEOUT + 1));
      check("wd_sticky", 64'(err_sticky), 64'd1);
      drain("drain_hang");
      late_req++;
      tick(5);
      check("late_ignored", {bus.out_valid, busy, state_dbg}, 64'd0);
      check("sticky_holds", 64'(err_sticky), 64'd1);

      // Reset in the middle of WAIT
      e0 = en_count;
      push_req(32'h4120_0000, 32'h40A0_0000, 4'd10, 32'h4000_0000, 1'b0, 1'b0);
      push_req(32'h4100_0000, 32'h4080_0000, 4'd11, 32'h4000_0000, 1'b0, 1'b0);
      tick(3);
      check("mid_wait_state", 64'(state_dbg), 64'd2);
      check("mid_wait_count", 64'(fifo_count), 64'd1);
      reset_n = 1'b0;
      #1;
      check("mrst_outs", {bus.out_valid, bus.out_nan, bus.out_timeout, bus.div_en, busy, err_sticky}, 64'd0);
      check("mrst_count", 64'(fifo_count), 64'd0);
      check("mrst_in_ready", 64'(bus.in_ready), 64'd1);
      check("mrst_data", {bus.out_result, bus.div_a}, 64'd0);
      exp_q.delete();
      hang = 1'b0;
      tick(2);
      reset_n = 1'b1;
      tick();
      push_req(32'h3F80_0000, 32'h4080_0000, 4'd5, 32'h3E80_0000, 1'b0, 1'b0);
      drain("drain_after_reset");
      check("en_reset_phase", 64'(en_count - e0), 64'd2);

      // Random table draws with an intermittent consumer
      e0 = en_count;
      for (int i = 0; i < 8; i++) begin
         idx = $urandom_range(0, 6);
         bus.out_ready = (fifo_count >= 3'd2) ? 1'b1 : 1'($urandom_range(0, 1));
         push_req(tab_a[idx], tab_b[idx], 4'(i), tab_q[idx], 1'b0, 1'b0);
         tick($urandom_range(0, 3));
      end
      bus.out_ready = 1'b1;
      drain("drain_random");
      check("en_random", 64'(en_count - e0), 64'd8);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end
endmodule
